// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_sub_full_sub.sv
// full_sub: combinational 1-bit full subtractor cell
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: LSB-first bit-serial a - b with start/done handshake
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d, borrow_q, borrow_d, zero_q, zero_d;
  logic             d, bout;
  logic [WIDTH-1:0] res_next;
  full_sub u_full_sub (
    .x   (a_sh_q[0]),
    .y   (b_sh_q[0]),
    .bin (bor_q),
    .d   (d),
    .bout(bout)
  );
  assign res_next = {d, res_sh_q[WIDTH-1:1]};
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? RUN : IDLE;
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          cnt_d    = '0;
          bor_d    = 1'b0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        bor_d    = bout;
        cnt_d    = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = res_next;
          borrow_d = bout;
          zero_d   = ~|res_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end
  assign busy       = state_q == RUN;
  assign done       = state_q == DONE;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed checks plus exhaustive sweep for serial_sub at WIDTH=4
module tb_serial_sub;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] a, b, diff;
  logic       busy, done, borrow_out, zero;
  int         errors = 0;
  int         checks = 0;
  serial_sub #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out),
    .zero      (zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    assert (!(done && busy)) else begin
      errors++;
      $error("FAIL done_with_busy observed=1 expected=0");
    end
  endtask
  task automatic expect_busy(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      tick();
    end
  endtask
  task automatic expect_done(input string tag, input logic [3:0] ed, input logic eb);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    check({tag, "_zero"}, 32'(zero), 32'(ed == 4'd0));
  endtask
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] ed, input logic eb);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av;
    b = ~bv;
    expect_busy(tag);
    expect_done(tag, ed, eb);
    tick();
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_out", {27'd0, diff, borrow_out}, 32'd0);
      check("idle_zero", 32'(zero), 32'd0);
    end
    run_op("t9m3", 4'd9, 4'd3, 4'd6, 1'b0);
    run_op("t3m9", 4'd3, 4'd9, 4'hA, 1'b1);
    run_op("t5m5", 4'd5, 4'd5, 4'd0, 1'b0);
    a = 4'd15;
    b = 4'd1;
    start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      a = 4'(i);
      b = 4'(i + 1);
      check("ign_busy", 32'(busy), 32'd1);
      tick();
    end
    start = 1'b0;
    expect_done("ign", 4'd14, 1'b0);
    tick();
    check("ign_dropped_busy", 32'(busy), 32'd0);
    check("ign_dropped_done", 32'(done), 32'd0);
    a = 4'd7;
    b = 4'd2;
    start = 1'b1;
    tick();
    expect_busy("b2b1");
    expect_done("b2b1", 4'd5, 1'b0);
    a = 4'd2;
    b = 4'd7;
    tick();
    expect_busy("b2b2");
    expect_done("b2b2", 4'hB, 1'b1);
    start = 1'b0;
    tick();
    check("b2b_end_busy", 32'(busy), 32'd0);
    a = 4'd9;
    b = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst_run2_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("rst_nodone", 32'(done), 32'd0);
      tick();
    end
    run_op("post_rst", 4'd12, 4'd4, 4'd8, 1'b0);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op("sweep", 4'(i), 4'(j), 4'((i - j) & 15), i < j);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
